// File: rtl/tt_io_trace_capture.sv
// Trace capture: waits for a masked trigger on mon_in, then stores every value change with a timestamp.
// Optional TRACE_DELTA_TS_EN: timestamps count cycles since the previous stored entry instead of since trigger.
module tt_io_trace_capture #(
    parameter int MON_W = 24,
    parameter int DEPTH = 16,
    parameter int TS_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MON_W-1:0]         mon_in,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     stop,
    input  logic [MON_W-1:0]         trig_mask,
    input  logic [MON_W-1:0]         trig_value,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [MON_W-1:0]         rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     ts_sat
);
    // state   | meaning
    // IDLE    | waiting for arm
    // ARMED   | waiting for masked trigger match
    // CAPTURE | recording value changes
    // DONE    | host drains entries
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TS_W-1:0] TS_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t             st_q, st_d;
    logic [MON_W-1:0]   mon_q;
    logic [TS_W-1:0]    ts_q, ts_d, ts_inc, wr_ts;
    logic               ts_sat_q, ts_sat_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_en, pop, trig_hit, changed;

    logic [MON_W-1:0]   mem_data [DEPTH];
    logic [TS_W-1:0]    mem_ts   [DEPTH];

    assign trig_hit = ((mon_in ^ trig_value) & trig_mask) == '0;
    assign changed  = mon_in != mon_q;
    assign ts_inc   = (ts_q == TS_MAX) ? ts_q : ts_q + TS_W'(1);

    assign rd_valid = (st_q == S_DONE) && (cnt_q != '0);
    assign rd_data  = rd_valid ? mem_data[rd_ptr] : '0;
    assign rd_ts    = rd_valid ? mem_ts[rd_ptr] : '0;
    assign count    = cnt_q;
    assign state    = st_q;
    assign ts_sat   = ts_sat_q;

    always_comb begin
        st_d     = st_q;
        ts_d     = ts_q;
        ts_sat_d = ts_sat_q;
        wr_en    = 1'b0;
        wr_ts    = '0;
        pop      = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (arm) st_d = S_ARMED;
            end
            S_ARMED: begin
                if (trig_hit) begin
                    wr_en = 1'b1;
                    ts_d  = TS_W'(1);
                    st_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                wr_en = changed;
                wr_ts = ts_q;
`ifdef TRACE_DELTA_TS_EN
                ts_d  = changed ? TS_W'(1) : ts_inc;
`else
                ts_d  = ts_inc;
`endif
                if (ts_d == TS_MAX) ts_sat_d = 1'b1;
                // the write that fills the last slot ends capture
                if (stop || (changed && cnt_q == CNT_W'(DEPTH - 1))) st_d = S_DONE;
            end
            S_DONE: begin
                pop = rd_valid && rd_ready;
                if (pop && cnt_q == CNT_W'(1)) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            st_q     <= S_IDLE;
            mon_q    <= '0;
            ts_q     <= '0;
            ts_sat_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            mon_q    <= mon_in;
            ts_q     <= ts_d;
            ts_sat_q <= ts_sat_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                cnt_q  <= cnt_q - CNT_W'(1);
            end
        end
    end

    // storage has no reset; count and pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && !abort && wr_en) begin
            mem_data[wr_ptr] <= mon_in;
            mem_ts[wr_ptr]   <= wr_ts;
        end
    end

endmodule

// File: doc/tt_io_trace_capture.md
Name: tt_io_trace_capture

Overview:
- Synthesizable logic-analyser block: watches a parametrised bus of DUT I/O (e.g. uo_out, uio_out, uio_oe concatenated), waits for a masked trigger, then records every value change with a cycle timestamp into an on-chip circular buffer.
- Sits beside the user project in the tt_um top. A host drains captured entries over a valid/ready read port.
- Generalises the fixed 8-bit I/O harness to arbitrary monitor width, depth and timestamp width, and adds trigger and storage behaviour.

Parameters:
- MON_W, 24, width of monitored bus (3 x 8-bit channels by default)
- DEPTH, 16, buffer entries; power of two, >= 2
- TS_W, 12, timestamp width in bits

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mon_in  in  MON_W  monitored bus, sampled every cycle
- arm  in  1  pulse: start waiting for trigger (honoured only in IDLE)
- abort  in  1  return to IDLE and discard buffer, from any state
- stop  in  1  end capture early (honoured only in CAPTURE)
- trig_mask  in  MON_W  1 = bit participates in trigger compare
- trig_value  in  MON_W  trigger pattern
- rd_valid  out  1  entry available at rd_data/rd_ts
- rd_ready  in  1  host accepts entry
- rd_data  out  MON_W  captured bus value
- rd_ts  out  TS_W  captured timestamp
- count  out  $clog2(DEPTH)+1  entries currently stored
- state  out  2  0=IDLE 1=ARMED 2=CAPTURE 3=DONE
- ts_sat  out  1  sticky: timestamp counter saturated during capture

Behaviour:
- Reset, or abort: state=IDLE, count=0, write/read pointers=0, ts=0, ts_sat=0, rd_valid=0, rd_data=0, rd_ts=0, mon_q=0. abort has priority over every other input except rst.
- mon_q is a register holding the previous-cycle mon_in. It is updated every cycle in every state.
- IDLE: arm=1 -> ARMED next cycle. All other inputs ignored.
- ARMED: in a cycle where (mon_in & trig_mask) == (trig_value & trig_mask):
  - entry {mon_in, ts=0} is written at that edge; count becomes 1.
  - state becomes CAPTURE; ts becomes 1.
  - trig_mask=0 triggers on the first ARMED cycle.
- CAPTURE:
  - ts increments by 1 each cycle and saturates at 2^TS_W-1. On reaching saturation, ts_sat is set.
  - In any cycle where mon_in != mon_q, entry {mon_in, ts} is written at that edge. count is visible one cycle later.
  - When the write makes count == DEPTH -> DONE.
  - stop=1 -> DONE. A change in the same cycle is still written.
  - stop with count already DEPTH cannot occur, because full forces DONE.
- DONE:
  - rd_valid = (count != 0). rd_data/rd_ts are driven combinationally from the entry at rd_ptr.
  - Handshake: pop on rd_valid & rd_ready. rd_ptr wraps modulo DEPTH; count decrements.
  - rd_valid must stay high and data stable until accepted.
  - When the pop makes count 0 -> IDLE next cycle. rd_valid goes low.
- rd_valid is 0 in every state other than DONE. No reads occur during capture.
- Pointers wrap modulo DEPTH. With DEPTH a power of two, pointer arithmetic drops the carry.
- Storage is a register array; no RAM macro.

Optional Feature:
- Macro TRACE_DELTA_TS_EN.
- Defined:
  - rd_ts holds cycles since the previous stored entry, not cycles since trigger. The trigger entry is still 0.
  - The delta counter resets to 1 after each write and saturates at 2^TS_W-1.
  - ts_sat is set if any delta saturates.
- Undefined: absolute timestamps since trigger, as described in Behaviour.

Test Plan:
- Reset mid-capture: rst at count=3 in CAPTURE -> next cycle state=0, count=0, rd_valid=0, ts_sat=0.
- Basic capture, DEPTH=16:
  - Stimulus: trig_mask=0x0000FF, trig_value=0x000005, arm. Hold mon_in=0x000000 for 4 cycles, set 0x000005, then 0x000106 after 3 more cycles, then stop.
  - Response: DONE with count=2. Entries read: (0x000005, ts 0) then (0x000106, ts 3).
- Fill to full:
  - Stimulus: toggle mon_in every cycle after trigger.
  - Response: DONE exactly when count=16 with 16 entries, ts 0..15. Changes after full are not stored.
  - Drain with rd_ready held high for 16 cycles -> IDLE, rd_valid low.
- Read backpressure: in DONE with count=2, hold rd_ready=0 for 5 cycles -> rd_valid=1 and rd_data/rd_ts unchanged. Then pulse rd_ready once -> count=1.
- Saturation, TS_W=4: trigger, then no change for 20 cycles, then one change -> entry ts=15 and ts_sat=1.
- Same stimulus with TRACE_DELTA_TS_EN defined:
  - Basic capture scenario -> ts sequence 0, 3.
  - A further change 2 cycles later -> ts 2.
- arm during CAPTURE and stop during ARMED are ignored; abort in DONE -> IDLE with count=0.
